// File: rtl/dma_request_arbiter_pkg.sv
// rtl/dma_request_arbiter_pkg.sv - shared types, encodings and widths for the DMA request arbiter
package dma_request_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } arb_state_e;

    // Watchdog counter width; a disabled watchdog still needs a legal 1-bit vector.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dma_request_arbiter_rr_priority_picker.sv
// rtl/dma_request_arbiter_rr_priority_picker.sv - combinational round-robin picker starting at a pointer
module rr_priority_picker
    import dma_request_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_index
);

    // Offset k from the pointer is scanned in increasing order; the first hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_valid && i_req[j] && (j == ((int'(i_ptr) + k) % N_REQ))) begin
                    o_valid = 1'b1;
                    o_index = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dma_request_arbiter.sv
// rtl/dma_request_arbiter.sv - round-robin arbiter sharing one DMA controller port among N devices
module dma_request_arbiter
    import dma_request_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_rqst,
    input  logic [N_REQ-1:0]          req_rd_wr,
    input  logic [DATA_W*N_REQ-1:0]   req_start_addr,
    input  logic [DATA_W*N_REQ-1:0]   req_num_words,
    input  logic [DATA_W*N_REQ-1:0]   req_dev_out,
    input  logic [N_REQ-1:0]          req_dev_ack,
    output logic [N_REQ-1:0]          req_dma_ack,
    output logic [N_REQ-1:0]          req_end_flag,
    output logic [N_REQ-1:0]          req_error_flag,
    output logic [DATA_W-1:0]         req_dev_in,
    output logic                      dma_rqst,
    output logic                      dma_rd_wr,
    output logic [DATA_W-1:0]         dma_start_address,
    output logic [DATA_W-1:0]         dma_num_words,
    output logic [DATA_W-1:0]         dev_out,
    output logic                      dev_ack,
    input  logic                      dma_ack,
    input  logic                      dma_end_flag,
    input  logic                      dma_error_flag,
    input  logic [DATA_W-1:0]         dev_in,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_busy
);

    localparam int              WD_W    = wdog_width(TIMEOUT);
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    arb_state_e      r_state;
    logic [ID_W-1:0] r_owner;
    logic [ID_W-1:0] r_rr_ptr;
    logic [WD_W-1:0] r_wdog;

    logic             w_pick_valid;
    logic [ID_W-1:0]  w_pick;
    logic             w_route;
    logic             w_wd_expire;
    logic             w_exit;
    logic             w_own_rqst;
    logic             w_own_rd_wr;
    logic             w_own_dev_ack;
    logic [DATA_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_num;
    logic [DATA_W-1:0] w_own_data;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .i_req   (req_rqst),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick)
    );

    always_comb begin
        w_own_rqst    = 1'b0;
        w_own_rd_wr   = 1'b0;
        w_own_dev_ack = 1'b0;
        w_own_addr    = '0;
        w_own_num     = '0;
        w_own_data    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_own_rqst    = req_rqst[i];
                w_own_rd_wr   = req_rd_wr[i];
                w_own_dev_ack = req_dev_ack[i];
                w_own_addr    = req_start_addr[DATA_W*i +: DATA_W];
                w_own_num     = req_num_words[DATA_W*i +: DATA_W];
                w_own_data    = req_dev_out[DATA_W*i +: DATA_W];
            end
        end
    end

    // Routing is suppressed while reset is asserted so a reset in BUSY never leaks a flag pulse.
    assign w_route     = (r_state == S_BUSY) && !reset;
    assign w_wd_expire = WD_EN && w_route && (r_wdog == WD_LAST) && !dma_ack;
    assign w_exit      = dma_end_flag | dma_error_flag | !w_own_rqst | w_wd_expire;

    always_comb begin
        dma_rqst          = w_route & w_own_rqst;
        dma_rd_wr         = w_route & w_own_rd_wr;
        dev_ack           = w_route & w_own_dev_ack;
        dma_start_address = w_route ? w_own_addr : '0;
        dma_num_words     = w_route ? w_own_num  : '0;
        dev_out           = w_route ? w_own_data : '0;
        req_dma_ack       = '0;
        req_end_flag      = '0;
        req_error_flag    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_route && (r_owner == ID_W'(i))) begin
                req_dma_ack[i]    = dma_ack;
                req_end_flag[i]   = dma_end_flag;
                req_error_flag[i] = dma_error_flag | w_wd_expire;
            end
        end
    end

    assign req_dev_in = dev_in;
    assign grant_id   = r_owner;
    assign arb_busy   = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (w_pick_valid) begin
                        r_owner  <= w_pick;
                        r_rr_ptr <= (w_pick == ID_W'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dma_ack) begin
                        r_wdog <= '0;
                    end else if (r_wdog != WD_MAX) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                    if (w_exit) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_request_arbiter.sv
// tb/tb_dma_request_arbiter.sv - randomized self-checking bench against a behavioural arbiter model
module tb_dma_request_arbiter;

    localparam int N   = 3;
    localparam int IDW = 3;
    localparam int TO  = 16;
    localparam int NCYC = 4000;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_rqst, req_rd_wr, req_dev_ack;
    logic [16*N-1:0] req_start_addr, req_num_words, req_dev_out;
    logic [N-1:0]    req_dma_ack, req_end_flag, req_error_flag;
    logic [15:0]     req_dev_in;
    logic            dma_rqst, dma_rd_wr, dev_ack;
    logic [15:0]     dma_start_address, dma_num_words, dev_out;
    logic            dma_ack, dma_end_flag, dma_error_flag;
    logic [15:0]     dev_in;
    logic [IDW-1:0]  grant_id;
    logic            arb_busy;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: who owns the port, whether the one-cycle gap is pending, and fairness pointer.
    bit m_busy = 0;
    bit m_gap  = 0;
    int m_owner = 0;
    int m_last  = 0;
    int m_next  = 0;
    int m_quiet = 0;

    dma_request_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_rqst(req_rqst), .req_rd_wr(req_rd_wr),
        .req_start_addr(req_start_addr), .req_num_words(req_num_words),
        .req_dev_out(req_dev_out), .req_dev_ack(req_dev_ack),
        .req_dma_ack(req_dma_ack), .req_end_flag(req_end_flag),
        .req_error_flag(req_error_flag), .req_dev_in(req_dev_in),
        .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
        .dev_out(dev_out), .dev_ack(dev_ack),
        .dma_ack(dma_ack), .dma_end_flag(dma_end_flag), .dma_error_flag(dma_error_flag),
        .dev_in(dev_in), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    initial begin
        int  ack_pct;
        bit  tie_flags;
        bit  route, expire;
        logic [N-1:0] e_ack, e_end, e_err;

        reset = 1'b1;
        req_rqst = '0; req_rd_wr = '0; req_dev_ack = '0;
        req_start_addr = '0; req_num_words = '0; req_dev_out = '0;
        dma_ack = 1'b0; dma_end_flag = 1'b0; dma_error_flag = 1'b0; dev_in = '0;
        ack_pct = 30; tie_flags = 0;
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 0;
                    1: ack_pct = 30;
                    default: ack_pct = 75;
                endcase
                tie_flags = ($urandom_range(0, 3) == 0);
            end
            reset = (cyc < 3) || ($urandom_range(0, 149) == 0);
            for (int d = 0; d < N; d++) begin
                if (req_rqst[d]) req_rqst[d] = ($urandom_range(0, 99) >= 3);
                else             req_rqst[d] = ($urandom_range(0, 99) < 20);
                req_rd_wr[d]   = $urandom_range(0, 1);
                req_dev_ack[d] = $urandom_range(0, 1);
                req_start_addr[16*d +: 16] = 16'($urandom);
                req_num_words[16*d +: 16]  = 16'($urandom);
                req_dev_out[16*d +: 16]    = 16'($urandom);
            end
            if (cyc < 3) req_rqst = '0;
            dma_ack        = ($urandom_range(0, 99) < ack_pct);
            dma_end_flag   = ($urandom_range(0, 99) < 6);
            dma_error_flag = tie_flags ? dma_end_flag : ($urandom_range(0, 99) < 3);
            dev_in         = 16'($urandom);
            #1;

            route  = m_busy && !reset;
            expire = route && (m_quiet == TO - 1) && !dma_ack;
            e_ack = '0; e_end = '0; e_err = '0;
            if (route) begin
                e_ack[m_owner] = dma_ack;
                e_end[m_owner] = dma_end_flag;
                e_err[m_owner] = dma_error_flag | expire;
            end
            check_val("dma_rqst", 64'(dma_rqst), 64'(route && req_rqst[m_owner]));
            check_val("dma_rd_wr", 64'(dma_rd_wr), 64'(route && req_rd_wr[m_owner]));
            check_val("dev_ack", 64'(dev_ack), 64'(route && req_dev_ack[m_owner]));
            check_val("start_addr", 64'(dma_start_address), route ? 64'(req_start_addr[16*m_owner +: 16]) : 64'd0);
            check_val("num_words", 64'(dma_num_words), route ? 64'(req_num_words[16*m_owner +: 16]) : 64'd0);
            check_val("dev_out", 64'(dev_out), route ? 64'(req_dev_out[16*m_owner +: 16]) : 64'd0);
            check_val("req_dma_ack", 64'(req_dma_ack), 64'(e_ack));
            check_val("req_end_flag", 64'(req_end_flag), 64'(e_end));
            check_val("req_error_flag", 64'(req_error_flag), 64'(e_err));
            check_val("req_dev_in", 64'(req_dev_in), 64'(dev_in));
            check_val("grant_id", 64'(grant_id), 64'(m_last));
            check_val("arb_busy", 64'(arb_busy), 64'(m_busy || m_gap));

            @(posedge clk);
            if (reset) begin
                m_busy = 0; m_gap = 0; m_owner = 0; m_last = 0; m_next = 0; m_quiet = 0;
            end else if (m_busy) begin
                if (dma_end_flag || dma_error_flag || !req_rqst[m_owner] || expire) begin
                    m_busy = 0;
                    m_gap  = 1;
                end
                m_quiet = dma_ack ? 0 : m_quiet + 1;
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int d;
                    d = (m_next + k) % N;
                    if (!m_busy && req_rqst[d]) begin
                        m_busy  = 1;
                        m_owner = d;
                        m_last  = d;
                        m_next  = (d + 1) % N;
                        m_quiet = 0;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
